// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage bus carrying the decode controls, the instruction ROM port and the decode-stage outputs.
// master (fetch side) receives stall, redirect_en/target and imem_q.
// It drives imem_address, decode_pc_address/instruction/valid and squash_count.
// slave is the mirror view for the decode stage, ROM and execute stage.
interface fetch_stage_if;
  logic        stall;
  logic        redirect_en;
  logic [11:0] redirect_target;
  logic [11:0] imem_address;
  logic [31:0] imem_q;
  logic [11:0] decode_pc_address;
  logic [31:0] decode_instruction;
  logic        decode_valid;
  logic [15:0] squash_count;
  modport master(
    input  stall, redirect_en, redirect_target, imem_q,
    output imem_address, decode_pc_address, decode_instruction, decode_valid, squash_count
  );
  modport slave(
    output stall, redirect_en, redirect_target, imem_q,
    input  imem_address, decode_pc_address, decode_instruction, decode_valid, squash_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: 12-bit PC fetch stage feeding the fetch/decode latch from a one-cycle-latency ROM, with stall replay and redirect squash.
// Ports: clock and reset (synchronous, active-high) plus bus (fetch_stage_if.master).
// bus carries the stall/redirect inputs, the ROM address/data pair and the registered decode outputs.
module fetch_stage #(
  parameter logic [11:0] RESET_PC = 12'd0,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic          clock,
  input logic          reset,
  fetch_stage_if.master bus
);
  logic [11:0] pc_q, pc_d, fetch_pc_q, fetch_pc_d, decode_pc_q, decode_pc_d;
  logic [31:0] decode_instr_q, decode_instr_d;
  logic        fetch_valid_q, fetch_valid_d, decode_valid_q, decode_valid_d;
  logic [15:0] squash_q, squash_d;
  logic        hold;
  // A redirect overrides a stall, so only a stall without redirect freezes the stage.
  always_comb begin
    hold           = bus.stall && !bus.redirect_en;
    pc_d           = bus.redirect_en ? bus.redirect_target : hold ? pc_q : pc_q + 12'd1;
    fetch_pc_d     = (bus.redirect_en || hold) ? fetch_pc_q : pc_q;
    fetch_valid_d  = !bus.redirect_en && (hold ? fetch_valid_q : 1'b1);
    decode_pc_d    = bus.redirect_en ? 12'd0 : hold ? decode_pc_q : fetch_pc_q;
    decode_instr_d = bus.redirect_en ? NOP_WORD : hold ? decode_instr_q : fetch_valid_q ? bus.imem_q : NOP_WORD;
    decode_valid_d = !bus.redirect_en && (hold ? decode_valid_q : fetch_valid_q);
    squash_d       = (bus.redirect_en && squash_q != 16'hFFFF) ? squash_q + 16'd1 : squash_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      fetch_pc_q     <= 12'd0;
      fetch_valid_q  <= 1'b0;
      decode_pc_q    <= 12'd0;
      decode_instr_q <= NOP_WORD;
      decode_valid_q <= 1'b0;
      squash_q       <= 16'd0;
    end else begin
      pc_q           <= pc_d;
      fetch_pc_q     <= fetch_pc_d;
      fetch_valid_q  <= fetch_valid_d;
      decode_pc_q    <= decode_pc_d;
      decode_instr_q <= decode_instr_d;
      decode_valid_q <= decode_valid_d;
      squash_q       <= squash_d;
    end
  end
  // While held, re-present the in-flight address so imem_q is still that word on release.
  assign bus.imem_address       = hold ? fetch_pc_q : pc_q;
  assign bus.decode_pc_address  = decode_pc_q;
  assign bus.decode_instruction = decode_instr_q;
  assign bus.decode_valid       = decode_valid_q;
  assign bus.squash_count       = squash_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven and scoreboard-checked bench for fetch_stage against a ROM holding 32'h1000_0000 + address.
module tb_fetch_stage;
  typedef struct {
    bit          rst;
    bit          stall;
    bit          redir;
    logic [11:0] tgt;
    logic [11:0] addr;
    bit          valid;
    logic [15:0] sq;
  } vec_t;
  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } ent_t;
  logic clock = 1'b0;
  logic reset;
  fetch_stage_if bus();
  vec_t vq[$];
  ent_t sb[$];
  ent_t last;
  bit   pushed;
  bit   held;
  int   checks = 0;
  int   fails  = 0;
  fetch_stage #(.RESET_PC(12'd0), .NOP_WORD(32'h0000_0000)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clock = ~clock;
  always_ff @(posedge clock) bus.imem_q <= 32'h1000_0000 + {20'd0, bus.imem_address};
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic add(input bit r, s, d, input logic [11:0] t, a, input bit v, input logic [15:0] q);
    vq.push_back('{r, s, d, t, a, v, q});
  endtask
  task automatic tick(input bit r, s, d, input logic [11:0] t, ea, input bit ev, input logic [15:0] es, input string tag);
    ent_t e;
    reset = r;
    bus.stall = s;
    bus.redirect_en = d;
    bus.redirect_target = t;
    #1;
    chk({tag, ".addr"}, {20'd0, bus.imem_address}, {20'd0, ea});
    chk({tag, ".valid"}, {31'd0, bus.decode_valid}, {31'd0, ev});
    chk({tag, ".squash"}, {16'd0, bus.squash_count}, {16'd0, es});
    if (!bus.decode_valid)
      chk({tag, ".nop"}, bus.decode_instruction, 32'h0);
    else if (held) begin
      chk({tag, ".hold_pc"}, {20'd0, bus.decode_pc_address}, {20'd0, last.a});
      chk({tag, ".hold_instr"}, bus.decode_instruction, last.d);
    end else if (sb.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s.sb: got word %h at %h expected no valid word", tag, bus.decode_instruction, bus.decode_pc_address);
    end else begin
      e = sb.pop_front();
      last = e;
      chk({tag, ".pc"}, {20'd0, bus.decode_pc_address}, {20'd0, e.a});
      chk({tag, ".instr"}, bus.decode_instruction, e.d);
    end
    if (r) sb.delete();
    else if (d) begin
      if (pushed) void'(sb.pop_back());
    end else if (!s) sb.push_back('{ea, 32'h1000_0000 + {20'd0, ea}});
    pushed = !r && !d && !s;
    held = s && !d && !r;
    @(negedge clock);
  endtask
  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_target = 12'd0;
    pushed = 1'b0;
    held = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst.addr", {20'd0, bus.imem_address}, 32'd0);
    chk("rst.pc", {20'd0, bus.decode_pc_address}, 32'd0);
    chk("rst.instr", bus.decode_instruction, 32'h0);
    chk("rst.valid", {31'd0, bus.decode_valid}, 32'd0);
    chk("rst.squash", {16'd0, bus.squash_count}, 32'd0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 12'd0, 12'(i), i >= 2, 16'd0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 12'd0, 12'd6, 1, 16'd0);
    for (int i = 7; i < 11; i++) add(0, 0, 0, 12'd0, 12'(i), 1, 16'd0);
    add(0, 0, 1, 12'h100, 12'd11, 1, 16'd0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 12'd0, 12'h100 + 12'(i), i >= 2, 16'd1);
    add(0, 1, 1, 12'h040, 12'h104, 1, 16'd1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 12'd0, 12'h040 + 12'(i), i >= 2, 16'd2);
    add(0, 0, 1, 12'hFFE, 12'h044, 1, 16'd2);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 12'd0, 12'hFFE + 12'(i), i >= 2, 16'd3);
    add(0, 0, 1, 12'h200, 12'd4, 1, 16'd3);
    add(0, 0, 1, 12'h300, 12'h200, 0, 16'd4);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 12'd0, 12'h300 + 12'(i), i >= 2, 16'd5);
    add(0, 0, 1, 12'h123, 12'h304, 1, 16'd5);
    add(1, 0, 0, 12'd0, 12'h123, 0, 16'd6);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 12'd0, 12'(i), i >= 2, 16'd0);
    foreach (vq[i])
      tick(vq[i].rst, vq[i].stall, vq[i].redir, vq[i].tgt, vq[i].addr, vq[i].valid, vq[i].sq, $sformatf("row%0d", i));
    tick(0, 1, 0, 12'd0, 12'd4, 1, 16'd0, "stall_pre_rst");
    tick(1, 1, 0, 12'd0, 12'd4, 1, 16'd0, "rst_in_stall");
    chk("after_rst.pc", {20'd0, bus.decode_pc_address}, 32'd0);
    tick(0, 0, 0, 12'd0, 12'd0, 0, 16'd0, "after_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
